// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu8bit command sequencer: opcodes, FSM states, widths.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_CMP = 3'b101;
  localparam logic [OP_W-1:0] OP_LDI = 3'b110;
  localparam logic [OP_W-1:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Operands and opcode presented to the ALU, latched at command accept.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR) || (op == OP_LDI);
  endfunction

  function automatic logic op_writes_flags(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DATA_W register file: one synchronous write port, two operand read ports
// and a debug read port, all reads combinational.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREG  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving an external combinational alu8bit.
// Define ALU_SEQ_CTRL_ALUREG_EN to add a CAPT state for a registered/slow ALU.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREG  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [IDX_W-1:0]  cmd_srca,
  input  logic [IDX_W-1:0]  cmd_srcb,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [FLAG_W-1:0] flags_q,
  input  logic [IDX_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data
);

  state_t            state_q, state_d;
  logic              accept, wb, rsp_done;
  alu_req_t          req_q;
  logic [IDX_W-1:0]  dst_q;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic              reg_we, flags_we;
  logic [DATA_W-1:0] reg_wdata, res_d;
  logic [FLAG_W-1:0] flags_d;

  alu_seq_regfile #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (reg_we),
    .waddr    (dst_q),
    .wdata    (reg_wdata),
    .ra_addr  (cmd_srca),
    .ra_data  (ra_data),
    .rb_addr  (cmd_srcb),
    .rb_data  (rb_data),
    .dbg_addr (rd_sel),
    .dbg_data (rd_data)
  );

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wb       = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
`ifdef ALU_SEQ_CTRL_ALUREG_EN
        state_d = S_CAPT;
`else
        wb      = 1'b1;
        state_d = S_RESP;
`endif
      end
      S_CAPT: begin
`ifdef ALU_SEQ_CTRL_ALUREG_EN
        wb      = 1'b1;
        state_d = S_RESP;
`else
        state_d = S_IDLE;
`endif
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback selection: LDI bypasses the ALU, illegal ops write nothing.
  always_comb begin
    reg_we    = wb && op_writes_reg(req_q.op);
    flags_we  = wb && op_writes_flags(req_q.op);
    reg_wdata = (req_q.op == OP_LDI) ? req_q.b : alu_result;
    flags_d   = flags_we ? alu_flags : flags_q;
    if (req_q.op == OP_ILL) begin
      res_d = '0;
    end else if (req_q.op == OP_LDI) begin
      res_d = req_q.b;
    end else begin
      res_d = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      dst_q      <= '0;
      flags_q    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // Operands captured at accept, so src == dst reads the pre-write value.
      if (accept) begin
        req_q.op <= cmd_op;
        req_q.a  <= ra_data;
        req_q.b  <= cmd_use_imm ? cmd_imm : rb_data;
        dst_q    <= cmd_dst;
      end
      if (flags_we) begin
        flags_q <= alu_flags;
      end
      if (wb) begin
        rsp_valid  <= 1'b1;
        rsp_result <= res_d;
        rsp_flags  <= flags_d;
        rsp_err    <= (req_q.op == OP_ILL);
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_a  = req_q.a;
  assign alu_b  = req_q.b;
  assign alu_op = req_q.op;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural alu8bit stand-in.
// Honors ALU_SEQ_CTRL_ALUREG_EN for the expected response latency.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int unsigned NREG  = 4;
  localparam int unsigned IDX_W = 2;
`ifdef ALU_SEQ_CTRL_ALUREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk, rst_n;
  logic              cmd_valid, cmd_ready, cmd_use_imm;
  logic [2:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_dst, cmd_srca, cmd_srcb, rd_sel;
  logic [7:0]        cmd_imm, alu_a, alu_b, alu_result, rsp_result, rd_data;
  logic [2:0]        alu_op;
  logic [3:0]        alu_flags, rsp_flags, flags_q;
  logic              rsp_valid, rsp_ready, rsp_err;

  alu_seq_ctrl #(.NREG(NREG), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_q(flags_q),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu8bit stand-in; flags = {V, C, N, Z}, C on SUB/CMP means "no borrow".
  logic [8:0] sum;
  always_comb begin
    alu_result = 8'hA5;
    alu_flags  = 4'hF;
    sum        = '0;
    case (alu_op)
      OP_ADD: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[7:0];
        alu_flags  = {(alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]), sum[8], sum[7], sum[7:0] == 8'h00};
      end
      OP_SUB, OP_CMP: begin
        sum        = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = sum[7:0];
        alu_flags  = {(alu_a[7] != alu_b[7]) && (sum[7] != alu_a[7]), ~sum[8], sum[7], sum[7:0] == 8'h00};
      end
      OP_AND: begin alu_result = alu_a & alu_b; alu_flags = {2'b00, alu_result[7], alu_result == 8'h00}; end
      OP_OR:  begin alu_result = alu_a | alu_b; alu_flags = {2'b00, alu_result[7], alu_result == 8'h00}; end
      OP_XOR: begin alu_result = alu_a ^ alu_b; alu_flags = {2'b00, alu_result[7], alu_result == 8'h00}; end
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst, srca, srcb;
    logic       use_imm;
    logic [7:0] imm, exp_a, exp_b, exp_res;
    logic [3:0] exp_fl;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[16];

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] dst, srca, srcb,
                              input logic ui, input logic [7:0] imm, a, b, res,
                              input logic [3:0] fl, input logic err);
    vec_t v;
    v.op = op; v.dst = dst; v.srca = srca; v.srcb = srcb; v.use_imm = ui; v.imm = imm;
    v.exp_a = a; v.exp_b = b; v.exp_res = res; v.exp_fl = fl; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare each response on its handshake cycle.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp actual=%0h required=none", rsp_result);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        chk("rsp_flags", 32'(rsp_flags), 32'(mon_e.fl));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic send(input vec_t v, output bit ok);
    @(posedge clk); #1;
    cmd_op = v.op; cmd_dst = v.dst; cmd_srca = v.srca; cmd_srcb = v.srcb;
    cmd_use_imm = v.use_imm; cmd_imm = v.imm; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=accept");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back('{v.exp_res, v.exp_fl, v.exp_err});
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    int n;
    send(v, ok);
    if (ok) begin
      @(negedge clk);
      chk($sformatf("v%0d_alu_op", idx), 32'(alu_op), 32'(v.op));
      chk($sformatf("v%0d_alu_a", idx), 32'(alu_a), 32'(v.exp_a));
      chk($sformatf("v%0d_alu_b", idx), 32'(alu_b), 32'(v.exp_b));
      chk($sformatf("v%0d_exec_cmd_ready", idx), 32'(cmd_ready), 32'd0);
      n = 1;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("v%0d_latency", idx), 32'(n), 32'(LAT));
      chk($sformatf("v%0d_flags_q", idx), 32'(flags_q), 32'(v.exp_fl));
      @(posedge clk);
    end
  endtask

  task automatic check_regs(input logic [31:0] exp, input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(exp[8*i +: 8]));
    end
  endtask

  initial begin
    bit ok;
    vec_t v;
    int n;

    vecs[0]  = mk(OP_LDI, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h01, 4'h0, 1'b0);
    vecs[1]  = mk(OP_LDI, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 4'h0, 1'b0);
    vecs[2]  = mk(OP_SUB, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h01, 8'h01, 8'h00, 4'h5, 1'b0);
    vecs[3]  = mk(OP_LDI, 2'd0, 2'd0, 2'd0, 1'b1, 8'h80, 8'h01, 8'h80, 8'h80, 4'h5, 1'b0);
    vecs[4]  = mk(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, 8'h80, 8'h01, 8'h81, 4'h2, 1'b0);
    vecs[5]  = mk(OP_LDI, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF, 8'h80, 8'hFF, 8'hFF, 4'h2, 1'b0);
    vecs[6]  = mk(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, 8'hFF, 8'h01, 8'h00, 4'h5, 1'b0);
    vecs[7]  = mk(OP_CMP, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 8'h01, 8'hFF, 8'h02, 4'h0, 1'b0);
    vecs[8]  = mk(OP_OR,  2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'hFF, 8'h01, 8'hFF, 4'h2, 1'b0);
    vecs[9]  = mk(OP_ILL, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 8'h01, 8'h01, 8'h00, 4'h2, 1'b1);
    vecs[10] = mk(OP_XOR, 2'd3, 2'd0, 2'd0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'h1, 1'b0);
    vecs[11] = mk(OP_AND, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03, 8'h01, 8'h03, 8'h01, 4'h0, 1'b0);
    vecs[12] = mk(OP_ADD, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h01, 8'h01, 8'h02, 4'h0, 1'b0);
    vecs[13] = mk(OP_CMP, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h02, 8'h02, 8'h00, 4'h5, 1'b0);
    vecs[14] = mk(OP_SUB, 2'd3, 2'd3, 2'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'hFF, 4'h2, 1'b0);
    vecs[15] = mk(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h7F, 8'h02, 8'h7F, 8'h81, 4'hA, 1'b0);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0;
    cmd_srcb = '0; cmd_use_imm = 1'b0; cmd_imm = '0; rsp_ready = 1'b0; rd_sel = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_flags_q", 32'(flags_q), 32'd0);
    chk("rst_alu_bus", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check_regs(32'h0, "rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready_same", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("rel_cmd_ready_next", 32'(cmd_ready), 32'd1);

    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], i);
    end
    @(negedge clk);
    check_regs(32'hFF8102FF, "table");
    chk("table_flags_q", 32'(flags_q), 32'hA);

    // Response stall: outputs hold, new command not accepted
    rsp_ready = 1'b0;
    v = mk(OP_LDI, 2'd2, 2'd0, 2'd0, 1'b1, 8'h5A, 8'hFF, 8'h5A, 8'h5A, 4'hA, 1'b0);
    send(v, ok);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    cmd_op = OP_ADD; cmd_dst = 2'd0; cmd_srca = 2'd1; cmd_use_imm = 1'b1; cmd_imm = 8'h11;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d_rsp_result", k), 32'(rsp_result), 32'h5A);
      chk($sformatf("stall%0d_rsp_flags", k), 32'(rsp_flags), 32'hA);
      chk($sformatf("stall%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    check_regs(32'hFF5A02FF, "stall");

    // Reset while in RESP
    @(posedge clk); #1 rst_n = 1'b0; cmd_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rresp_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rresp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rresp_flags_q", 32'(flags_q), 32'd0);
    check_regs(32'h0, "rresp");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset right after accept: no writeback
    rsp_ready = 1'b1;
    v = mk(OP_LDI, 2'd0, 2'd0, 2'd0, 1'b1, 8'h77, 8'h00, 8'h77, 8'h77, 4'h0, 1'b0);
    send(v, ok);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    check_regs(32'h0, "rexec");
    @(posedge clk); #1 rst_n = 1'b1;

    // Recovery after reset
    run_vec(mk(OP_LDI, 2'd1, 2'd0, 2'd0, 1'b1, 8'h3C, 8'h00, 8'h3C, 8'h3C, 4'h0, 1'b0), 99);
    @(negedge clk);
    check_regs(32'h00003C00, "recov");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Command-driven sequencer that owns a small 8-bit register file and drives the team's alu8bit datapath (a, b, opcode -> result, flags). It accepts one instruction per valid/ready handshake, fetches operands, presents them to the ALU, writes back the result and flags, and returns a response. It is the layer between test/stimulus logic or a future fetch unit and the combinational ALU.

Parameters:
NREG, 4, number of 8-bit general registers (power of two, 2..16)
IDX_W, 2, register index width, equal to log2(NREG)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CMP, 110 LDI, 111 illegal
cmd_dst  in  IDX_W  destination register
cmd_srca  in  IDX_W  operand A register
cmd_srcb  in  IDX_W  operand B register
cmd_use_imm  in  1  operand B = cmd_imm instead of reg[cmd_srcb]
cmd_imm  in  8  immediate value
alu_a  out  8  to ALU a
alu_b  out  8  to ALU b
alu_op  out  3  to ALU opcode
alu_result  in  8  from ALU result
alu_flags  in  4  from ALU flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_result  out  8  result of the command
rsp_flags  out  4  flags after the command
rsp_err  out  1  command was illegal
flags_q  out  4  architectural flag register
rd_sel  in  IDX_W  debug read select
rd_data  out  8  combinational reg[rd_sel]

Behaviour:
- Reset, synchronous on rst_n=0: state IDLE, all registers 0, flags_q 0, alu_a/alu_b/alu_op 0, rsp_* 0, cmd_ready 0 during reset and 1 the cycle after release.
- FSM: IDLE -> EXEC -> RESP -> IDLE. With the optional feature: IDLE -> EXEC -> CAPT -> RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, dst, A=reg[srca], and B=use_imm ? imm : reg[srcb]. Go to EXEC.
- EXEC: cmd_ready=0. alu_a, alu_b and alu_op come from registered values, so they are stable for the whole cycle. At the end of the cycle, capture alu_result and alu_flags.
- Writeback happens at the end of EXEC.
  - ADD, SUB, AND, OR, XOR: reg[dst] <= alu_result; flags_q <= alu_flags.
  - CMP: flags_q <= alu_flags; no register write; rsp_result = alu_result.
  - LDI: reg[dst] <= latched B (the immediate); flags_q unchanged; rsp_result = B. The ALU outputs are ignored.
  - 111: no write, flags_q unchanged, rsp_err=1, rsp_result=0.
- RESP: rsp_valid=1. rsp_result, rsp_flags (= flags_q after writeback) and rsp_err hold stable until rsp_ready=1. Leave on the rsp_valid&rsp_ready cycle. cmd_ready=0 in RESP, so there is no accept in the same cycle as the response handshake.
- Latency: accept at cycle T; rsp_valid at T+2 (T+3 with feature). Peak throughput is one command per 3 cycles.
- Hazards: operands are latched at accept, so src==dst is legal and reads the old value. The next command sees the updated register.
- rd_data is combinational from the register array and reflects a write on the cycle after the write edge.
- alu_a, alu_b and alu_op hold their last value outside EXEC.
- Reset mid-operation, in any state, returns to IDLE. A pending response is discarded and no writeback occurs.
- Index fields wrap naturally to IDX_W bits.

Optional Feature:
ALU_SEQ_CTRL_ALUREG_EN
- Defined: adds a CAPT state. alu_* are held through EXEC and CAPT. alu_result and alu_flags are sampled at the end of CAPT, which tolerates a registered or slow ALU. Writeback happens at the end of CAPT. Latency is +1.
- Undefined: CAPT is absent and the FSM is as described above.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_ILL (3-bit)
  - state encodings S_IDLE, S_EXEC, S_CAPT, S_RESP
  - DATA_W=8 and FLAG_W=4
- Natural sub-module: alu_seq_regfile, an NREG x 8 array with one synchronous write port and two combinational read ports plus the debug port.
- alu8bit stays outside; the bench connects it.

Test Plan:
- Reset, then LDI r0=0x01 and LDI r1=0x01 -> each rsp at T+2, rsp_result=0x01, flags_q stays 0, rd_data(r0)=0x01.
- SUB r2=r0-r1 -> alu_op=001, alu_a=alu_b=0x01 during EXEC; rsp_result=0x00; r2=0x00; flags_q equals alu8bit's flags for 0x01-0x01 (zero set).
- LDI r0=0x80, then ADD r3=r0+imm 0x01 -> rsp_result=0x81; next, LDI r0=0xFF then ADD r3=r0+imm 0x01 -> rsp_result=0x00 with alu8bit's carry flag in flags_q.
- CMP r1,r1 after ADD -> r1 unchanged, flags_q updated, rsp_err=0. Then op 111 -> rsp_err=1, no register or flag change.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, a new cmd_valid is not accepted. Then assert rst_n=0 in RESP -> IDLE, all registers 0, rsp_valid=0 the next cycle.
- Build with ALU_SEQ_CTRL_ALUREG_EN and repeat the SUB case -> rsp_valid at T+3, same results.
